// File: rtl/vga_sync_recover.sv
// Recovers x/y pixel coordinates and frame lock from a line/frame-active sync pair.
// Optional saturating error counter port o_err_count is enabled by defining VGA_SYNC_ERR_COUNT_EN.
module vga_sync_recover #(
    parameter int WIDTH         = 800,
    parameter int HEIGHT        = 525,
    parameter int WIDTH_ACTIVE  = 640,
    parameter int HEIGHT_ACTIVE = 480,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic        o_active,
    output logic        o_locked,
    output logic        o_line_err
`ifdef VGA_SYNC_ERR_COUNT_EN
    ,
    output logic [7:0]  o_err_count
`endif
);

    localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);
    localparam logic [10:0] X_ACT  = 11'(WIDTH_ACTIVE);
    localparam logic [10:0] Y_ACT  = 11'(HEIGHT_ACTIVE);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        ferr_q, ferr_d;

    logic        h_prev_q, v_prev_q;
    logic        hs_q, vs_q;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        err_q, err_d;

    logic        h_rise, h_fall, v_rise, v_fall, wrap, viol;

    assign h_rise = i_hsync & ~h_prev_q;
    assign h_fall = ~i_hsync & h_prev_q;
    assign v_rise = i_vsync & ~v_prev_q;
    assign v_fall = ~i_vsync & v_prev_q;
    assign wrap   = (x_q == X_LAST);

    always_comb begin
        x_d = x_q + 11'd1;
        if (h_rise || wrap) begin
            x_d = '0;
        end

        y_d = y_q;
        if (v_rise) begin
            y_d = '0;
        end else if (x_d == '0) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
        end

        // All violations in one sample collapse into a single error
        viol = (h_rise & ~wrap)
             | (wrap & ~h_rise)
             | (h_fall & (x_d != X_ACT))
             | (v_rise & ((y_q != Y_LAST) | ~h_rise))
             | (v_fall & (y_d != Y_ACT));
        err_d = viol & (state_q != SEARCH);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_prev_q <= 1'b1;
            v_prev_q <= 1'b1;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            h_prev_q <= i_hsync;
            v_prev_q <= i_vsync;
            hs_q     <= i_hsync;
            vs_q     <= i_vsync;
            x_q      <= x_d;
            y_q      <= y_d;
            err_q    <= err_d;
        end
    end

    // ferr_q remembers an error somewhere in the frame that ends at the next vsync rise
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        ferr_d  = ferr_q;
        case (state_q)
            SEARCH: begin
                if (v_rise) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                    ferr_d  = 1'b0;
                end
            end
            ACQUIRE: begin
                if (v_rise) begin
                    ferr_d = 1'b0;
                    if (err_d || ferr_q) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (err_d) begin
                    good_d = '0;
                    ferr_d = 1'b1;
                end
            end
            LOCKED: begin
                if (err_d) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                    ferr_d  = ~v_rise;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
                ferr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SEARCH;
            good_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef VGA_SYNC_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign o_err_count = err_cnt_q;
`endif

    assign o_hsync    = hs_q;
    assign o_vsync    = vs_q;
    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_line_err = err_q;
    assign o_locked   = (state_q == LOCKED);
    assign o_active   = o_locked & hs_q & vs_q;

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed self-checking bench for vga_sync_recover on a 10x6 (8x4 active) timing.
module tb_vga_sync_recover;

    localparam int W  = 10;
    localparam int H  = 6;
    localparam int WA = 8;
    localparam int HA = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync, vsync;
    logic        o_hsync, o_vsync, o_active, o_locked, o_line_err;
    logic [10:0] o_x, o_y;
`ifdef VGA_SYNC_ERR_COUNT_EN
    logic [7:0]  o_err_count;
`endif

    int checks = 0;
    int errors = 0;

    vga_sync_recover #(
        .WIDTH(W),
        .HEIGHT(H),
        .WIDTH_ACTIVE(WA),
        .HEIGHT_ACTIVE(HA),
        .LOCK_FRAMES(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_hsync(hsync),
        .i_vsync(vsync),
        .o_hsync(o_hsync),
        .o_vsync(o_vsync),
        .o_x(o_x),
        .o_y(o_y),
        .o_active(o_active),
        .o_locked(o_locked),
        .o_line_err(o_line_err)
`ifdef VGA_SYNC_ERR_COUNT_EN
        ,
        .o_err_count(o_err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One sample per call; outputs reflecting this sample are visible on return.
    task automatic drive(input logic h, input logic v);
        hsync = h;
        vsync = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0);
    endtask

    task automatic stream_frame(input int lines, input int short_y,
                                output int nerr, output logic lock0, output logic lockany);
        int len;
        nerr    = 0;
        lock0   = 1'b0;
        lockany = 1'b0;
        for (int y = 0; y < lines; y++) begin
            len = (y == short_y) ? W - 1 : W;
            for (int x = 0; x < len; x++) begin
                drive(x < WA, y < HA);
                if (y == 0 && x == 0) lock0 = o_locked;
                if (o_line_err) nerr++;
                if (o_locked) lockany = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_x, o_y} !== 22'd0) begin
            errors++;
            $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", o_x, o_y);
        end
        checks++;
        if ({o_hsync, o_vsync, o_active, o_locked, o_line_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {o_hsync, o_vsync, o_active, o_locked, o_line_err});
        end
`ifdef VGA_SYNC_ERR_COUNT_EN
        checks++;
        if (o_err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_errcnt: got %0d expected 0", o_err_count);
        end
`endif
    endtask

    task automatic test_clean();
        logic h, v, lk;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    h  = (x < WA);
                    v  = (y < HA);
                    lk = (f >= 2);
                    drive(h, v);
                    checks++;
                    if (o_x !== 11'(x) || o_y !== 11'(y)) begin
                        errors++;
                        $display("FAIL clean_xy f%0d: got x=%0d y=%0d expected x=%0d y=%0d",
                                 f, o_x, o_y, x, y);
                    end
                    checks++;
                    if (o_line_err !== 1'b0) begin
                        errors++;
                        $display("FAIL clean_err f%0d y%0d x%0d: got %b expected 0", f, y, x, o_line_err);
                    end
                    checks++;
                    if (o_locked !== lk || o_active !== (lk & h & v)) begin
                        errors++;
                        $display("FAIL clean_lock f%0d y%0d x%0d: got locked=%b active=%b expected %b %b",
                                 f, y, x, o_locked, o_active, lk, lk & h & v);
                    end
                end
            end
        end
`ifdef VGA_SYNC_ERR_COUNT_EN
        checks++;
        if (o_err_count !== 8'd0) begin
            errors++;
            $display("FAIL clean_errcnt: got %0d expected 0", o_err_count);
        end
`endif
    endtask

    task automatic test_early_hsync();
        int   nerr;
        logic l0, la;
        do_reset();
        stream_frame(H, -1, nerr, l0, la);
        stream_frame(H, -1, nerr, l0, la);
        stream_frame(H, 1, nerr, l0, la);
        checks++;
        if (l0 !== 1'b1 || nerr != 1) begin
            errors++;
            $display("FAIL early_pulse: got lock0=%b pulses=%0d expected 1 1", l0, nerr);
        end
        checks++;
        if (o_locked !== 1'b0) begin
            errors++;
            $display("FAIL early_unlock: got %b expected 0", o_locked);
        end
        stream_frame(H, -1, nerr, l0, la);
        checks++;
        if (l0 !== 1'b0 || la !== 1'b0 || nerr != 0) begin
            errors++;
            $display("FAIL early_f3: got lock0=%b any=%b pulses=%0d expected 0 0 0", l0, la, nerr);
        end
        stream_frame(H, -1, nerr, l0, la);
        checks++;
        if (l0 !== 1'b0 || la !== 1'b0) begin
            errors++;
            $display("FAIL early_f4: got lock0=%b any=%b expected 0 0", l0, la);
        end
        stream_frame(H, -1, nerr, l0, la);
        checks++;
        if (l0 !== 1'b1 || nerr != 0) begin
            errors++;
            $display("FAIL early_relock: got lock0=%b pulses=%0d expected 1 0", l0, nerr);
        end
`ifdef VGA_SYNC_ERR_COUNT_EN
        checks++;
        if (o_err_count !== 8'd1) begin
            errors++;
            $display("FAIL early_errcnt: got %0d expected 1", o_err_count);
        end
`endif
    endtask

    task automatic test_missing_hsync();
        int   nerr;
        logic l0, la;
        do_reset();
        stream_frame(H, -1, nerr, l0, la);
        nerr = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                drive((x < WA) && (y != 2), y < HA);
                if (o_line_err) nerr++;
                if (y == 1 && x == 9) begin
                    checks++;
                    if (o_x !== 11'd9 || o_y !== 11'd1) begin
                        errors++;
                        $display("FAIL miss_pre: got x=%0d y=%0d expected 9 1", o_x, o_y);
                    end
                end
                if (y == 2 && x == 0) begin
                    checks++;
                    if (o_x !== 11'd0 || o_y !== 11'd2 || o_line_err !== 1'b1) begin
                        errors++;
                        $display("FAIL miss_wrap: got x=%0d y=%0d err=%b expected 0 2 1",
                                 o_x, o_y, o_line_err);
                    end
                end
                if (y == 3 && x == 0) begin
                    checks++;
                    if (o_x !== 11'd0 || o_y !== 11'd3) begin
                        errors++;
                        $display("FAIL miss_next: got x=%0d y=%0d expected 0 3", o_x, o_y);
                    end
                end
            end
        end
        checks++;
        if (nerr != 1) begin
            errors++;
            $display("FAIL miss_count: got %0d pulses expected 1", nerr);
        end
    endtask

    task automatic test_wrong_length();
        int   nerr, total;
        logic l0, la, anylock;
        do_reset();
        total   = 0;
        anylock = 1'b0;
        for (int f = 0; f < 5; f++) begin
            stream_frame(7, -1, nerr, l0, la);
            total += nerr;
            anylock |= la;
        end
        checks++;
        if (total != 4) begin
            errors++;
            $display("FAIL wronglen_errs: got %0d pulses expected 4", total);
        end
        checks++;
        if (anylock !== 1'b0) begin
            errors++;
            $display("FAIL wronglen_lock: got %b expected 0", anylock);
        end
    endtask

    task automatic test_reset_midframe();
        int   nerr;
        logic l0, la;
        do_reset();
        stream_frame(H, -1, nerr, l0, la);
        stream_frame(H, -1, nerr, l0, la);
        for (int s = 0; s < 2 * W + 5; s++) begin
            drive((s % W) < WA, (s / W) < HA);
        end
        checks++;
        if (o_x !== 11'd4 || o_y !== 11'd2 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got x=%0d y=%0d lock=%b expected 4 2 1", o_x, o_y, o_locked);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_x, o_y} !== 22'd0 ||
            {o_hsync, o_vsync, o_active, o_locked, o_line_err} !== 5'b0) begin
            errors++;
            $display("FAIL mid_async: got x=%0d y=%0d flags=%b expected 0 0 00000",
                     o_x, o_y, {o_hsync, o_vsync, o_active, o_locked, o_line_err});
        end
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        checks++;
        if (o_x !== 11'd0 || o_hsync !== 1'b0) begin
            errors++;
            $display("FAIL mid_held: got x=%0d hs=%b expected 0 0", o_x, o_hsync);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b1);
        checks++;
        if (o_x !== 11'd1 || o_y !== 11'd0 || o_hsync !== 1'b1 ||
            o_line_err !== 1'b0 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL mid_norise: got x=%0d y=%0d hs=%b err=%b lock=%b expected 1 0 1 0 0",
                     o_x, o_y, o_hsync, o_line_err, o_locked);
        end
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        checks++;
        if (o_x !== 11'd0 || o_y !== 11'd1 || o_active !== 1'b0) begin
            errors++;
            $display("FAIL mid_rise: got x=%0d y=%0d act=%b expected 0 1 0", o_x, o_y, o_active);
        end
    endtask

`ifdef VGA_SYNC_ERR_COUNT_EN
    task automatic test_err_saturation();
        do_reset();
        drive(1'b1, 1'b1);
        for (int i = 0; i < 600; i++) begin
            drive((i % 2) == 1, 1'b1);
            if (i == 0) begin
                checks++;
                if (o_err_count !== 8'd1 || o_line_err !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_first: got cnt=%0d err=%b expected 1 1", o_err_count, o_line_err);
                end
            end
        end
        checks++;
        if (o_err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 255", o_err_count);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        test_reset();
        test_clean();
        test_early_hsync();
        test_missing_hsync();
        test_wrong_length();
        test_reset_midframe();
`ifdef VGA_SYNC_ERR_COUNT_EN
        test_err_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
